// File: rtl/wb_csr_bank_pkg.sv
// Shared definitions for the Wishbone CSR bank: FSM states, CSR word offsets, data width.
package wb_csr_bank_pkg;
  localparam int DATA_W = 32;

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  localparam int CSR_CTRL   = 0;
  localparam int CSR_STATUS = 1;
  localparam int CSR_LAT    = 2;
  localparam int CSR_TIMING = 3;
endpackage

// File: rtl/wb_csr_byte_merge.sv
// Byte-lane merge: selected lanes take the new word, the rest keep the old word.
module wb_csr_byte_merge
  import wb_csr_bank_pkg::*;
(
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   new_word,
  input  logic [DATA_W/8-1:0] sel,
  output logic [DATA_W-1:0]   merged
);
  for (genvar b = 0; b < DATA_W/8; b++) begin : g_lane
    assign merged[8*b +: 8] = sel[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
  end
endmodule

// File: rtl/wb_csr_bank.sv
// Wishbone classic slave in front of the CSR file: one-hot write pulses, byte-merged data, read mux.
// Optional macro WB_CSR_ERR_EN: out-of-range / read-only writes end with wb_err_o instead of wb_ack_o.
module wb_csr_bank
  import wb_csr_bank_pkg::*;
#(
  parameter int               NREGS   = 4,
  parameter int               ADDR_W  = 6,
  parameter logic [NREGS-1:0] RO_MASK = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDR_W-1:0]       wb_adr_i,
  input  logic [3:0]              wb_sel_i,
  input  logic [DATA_W-1:0]       wb_dat_i,
  output logic [DATA_W-1:0]       wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic [NREGS-1:0]        reg_wren_o,
  output logic [DATA_W-1:0]       reg_wdata_o,
  input  logic [NREGS*DATA_W-1:0] reg_rdata_i
);
  localparam int IDX_W = ADDR_W - 2;

  state_t            state;
  logic [IDX_W-1:0]  idx, idx_q;
  logic              wr_ok_q;
  logic              in_range, hit_ro, accept, err_d;
  logic [DATA_W-1:0] rdata_sel, merged_d;
  logic              unused_adr_lsb;

  assign unused_adr_lsb = &{1'b0, wb_adr_i[1:0]};
  assign idx      = wb_adr_i[ADDR_W-1:2];
  assign in_range = ({1'b0, idx} < (IDX_W+1)'(NREGS));
  assign accept   = (state == S_IDLE) && wb_cyc_i && wb_stb_i;

  // Out-of-range indices fall through with zero data and no read-only hit.
  always_comb begin
    rdata_sel = '0;
    hit_ro    = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == IDX_W'(i)) begin
        rdata_sel = reg_rdata_i[DATA_W*i +: DATA_W];
        hit_ro    = RO_MASK[i];
      end
    end
  end

`ifdef WB_CSR_ERR_EN
  assign err_d = !in_range || (wb_we_i && hit_ro);
`else
  assign err_d = 1'b0;
`endif

  wb_csr_byte_merge u_merge (
    .old_word (rdata_sel),
    .new_word (wb_dat_i),
    .sel      (wb_sel_i),
    .merged   (merged_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx_q       <= '0;
      wr_ok_q     <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= '0;
      reg_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          state       <= S_RESP;
          idx_q       <= idx;
          wr_ok_q     <= wb_we_i && in_range && !hit_ro;
          reg_wdata_o <= merged_d;
          wb_dat_o    <= (!wb_we_i && in_range) ? rdata_sel : '0;
          wb_ack_o    <= !err_d;
          wb_err_o    <= err_d;
        end
        S_RESP: begin
          state    <= S_IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          wb_dat_o <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Pulse is gated live by wb_cyc_i so a master abort during RESP kills the write.
  always_comb begin
    reg_wren_o = '0;
    if (state == S_RESP && wr_ok_q && wb_cyc_i)
      for (int i = 0; i < NREGS; i++)
        reg_wren_o[i] = (idx_q == IDX_W'(i));
  end
endmodule

// File: tb/tb_wb_csr_bank.sv
// Self-checking bench for wb_csr_bank: directed cases plus random transfers against a CSR array model.
module tb_wb_csr_bank;
  localparam int         NREGS = 4;
  localparam int         AW    = 6;
  localparam logic [3:0] RO    = 4'b1000;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [AW-1:0]      adr = '0;
  logic [3:0]         sel = '0;
  logic [31:0]        dat_i = '0;
  logic [31:0]        dat_o, wdata;
  logic               ack, err;
  logic [NREGS-1:0]   wren;
  logic [NREGS*32-1:0] rdata;

  logic [31:0] csr     [NREGS];   // environment storage (the register_rw instances)
  logic [31:0] exp_reg [NREGS];   // reference model
  logic [31:0] init_v  [NREGS];

  int n_chk = 0, n_err = 0;
  int wren_cycles = 0, wren_viol = 0;

  always #5 clk = ~clk;

  wb_csr_bank #(.NREGS(NREGS), .ADDR_W(AW), .RO_MASK(RO)) dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i), .wb_dat_o(dat_o),
    .wb_ack_o(ack), .wb_err_o(err), .reg_wren_o(wren), .reg_wdata_o(wdata),
    .reg_rdata_i(rdata)
  );

  initial begin
    init_v[0] = 32'h0000_0001; init_v[1] = 32'h0000_0000;
    init_v[2] = 32'h0000_0000; init_v[3] = 32'hA5A5_5A5A;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < NREGS; i++) csr[i] <= init_v[i];
    else for (int i = 0; i < NREGS; i++) if (wren[i]) csr[i] <= wdata;
  end

  always_comb for (int i = 0; i < NREGS; i++) rdata[32*i +: 32] = csr[i];

  // Pulse bookkeeping: more than one bit, or a pulse with no ack, is a violation.
  always @(negedge clk) if (rst_n) begin
    if (wren != 0) wren_cycles++;
    if ($countones(wren) > 1 || (wren != 0 && !ack)) wren_viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return m;
  endfunction

  function automatic bit exp_err(input bit w, input int idx);
`ifdef WB_CSR_ERR_EN
    return (idx >= NREGS) || (w && RO[idx[1:0]]);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) exp_reg[i] = init_v[i];
  endtask

  // One complete transfer with master holding cyc/stb until the response cycle ends.
  task automatic xfer(input bit w, input int idx, input logic [3:0] s, input logic [31:0] d);
    bit          inr = (idx < NREGS);
    bit          ro  = inr && RO[idx[1:0]];
    bit          e   = exp_err(w, idx);
    logic [31:0] old = inr ? exp_reg[idx[1:0]] : 32'h0;
    logic [31:0] m   = merge(old, d, s);
    logic [NREGS-1:0] ew = (w && inr && !ro) ? NREGS'(1 << idx) : '0;
    logic [3:0]  lsb = 4'($urandom_range(0, 3));
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = {idx[3:0], lsb[1:0]}; sel = s; dat_i = d;
    @(posedge clk); #1;
    check($sformatf("ack idx%0d we%0d", idx, w), 32'(ack), 32'(!e));
    check($sformatf("err idx%0d we%0d", idx, w), 32'(err), 32'(e));
    check($sformatf("wren idx%0d we%0d", idx, w), 32'(wren), 32'(ew));
    if (w && inr) check($sformatf("wdata idx%0d", idx), wdata, m);
    if (!w)       check($sformatf("rdat idx%0d", idx), dat_o, inr ? old : 32'h0);
    @(posedge clk); #1;
    cyc = 0; stb = 0;
    check("ack idle", 32'(ack), 32'h0);
    if (ew != 0) exp_reg[idx[1:0]] = m;
  endtask

  initial begin
    int base;
    logic [31:0] d[3];
    model_reset();
    // reset state
    repeat (2) @(negedge clk);
    check("rst ack", 32'(ack), 0);
    check("rst err", 32'(err), 0);
    check("rst wren", 32'(wren), 0);
    check("rst dat_o", dat_o, 0);
    check("rst wdata", wdata, 0);
    rst_n = 1;

    xfer(1, 1, 4'hF, 32'hDEADBEEF);
    check("csr1 stored", csr[1], 32'hDEADBEEF);
    xfer(1, 2, 4'hF, 32'h11223344);
    xfer(1, 2, 4'b0010, 32'h0000AB00);
    check("csr2 merged", csr[2], 32'h1122AB44);
    xfer(0, 2, 4'h0, 32'h0);
    xfer(1, 3, 4'hF, 32'h12345678);   // read-only
    xfer(0, 3, 4'hF, 32'h0);
    xfer(0, 7, 4'hF, 32'h0);          // out of range read
    xfer(1, 9, 4'hF, 32'hFFFFFFFF);   // out of range write

    // three back-to-back writes with stb held
    d[0] = 32'h0BAD_F00D; d[1] = 32'hCAFE_0001; d[2] = 32'h5555_AAAA;
    base = wren_cycles;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 6'h00; sel = 4'hF; dat_i = d[0];
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b ack%0d", k), 32'(ack), 1);
      check($sformatf("b2b wren%0d", k), 32'(wren), 32'h1);
      check($sformatf("b2b wdata%0d", k), wdata, d[k]);
      if (k < 2) dat_i = d[k+1];
      @(posedge clk); #1;
      check($sformatf("b2b gap%0d", k), 32'(ack), 0);
      if (k == 2) begin cyc = 0; stb = 0; end
    end
    exp_reg[0] = d[2];
    repeat (2) @(posedge clk); #1;
    check("b2b pulses", 32'(wren_cycles - base), 3);
    xfer(0, 0, 4'hF, 32'h0);

    // abort: cyc drops during the response cycle
    base = wren_cycles;
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 6'h04; sel = 4'hF; dat_i = 32'h7777_7777;
    @(posedge clk); #1;
    check("abort ack", 32'(ack), 1);
    @(negedge clk); cyc = 0; stb = 0; #1;
    check("abort wren", 32'(wren), 0);
    @(posedge clk); #1;
    check("abort pulses", 32'(wren_cycles - base), 0);
    xfer(0, 1, 4'hF, 32'h0);

    // reset during the response cycle
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 6'h08; sel = 4'hF; dat_i = 32'h9999_0000;
    @(posedge clk); #1;
    check("pre-rst wren", 32'(wren), 32'h4);
    rst_n = 0; #1;
    check("mid-rst ack", 32'(ack), 0);
    check("mid-rst wren", 32'(wren), 0);
    cyc = 0; stb = 0;
    model_reset();
    @(negedge clk); rst_n = 1;
    xfer(0, 2, 4'hF, 32'h0);
    xfer(1, 0, 4'h3, 32'hFEED_BEEF);

    // random transfers
    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    for (int i = 0; i < NREGS; i++) xfer(0, i, 4'h0, 32'h0);

    check("wren onehot/gated", 32'(wren_viol), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
